// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light display path: stage codes, segment patterns
// and the converter state type.
package traffic_pkg;

    localparam logic [1:0] STAGE_R = 2'b00;
    localparam logic [1:0] STAGE_G = 2'b01;
    localparam logic [1:0] STAGE_Y = 2'b10;
    localparam logic [1:0] STAGE_X = 2'b11;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'b00,
        CONV_SHIFT = 2'b01,
        CONV_DONE  = 2'b10
    } conv_state_t;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 5-bit binary to two BCD digits, one shift per cycle.
// state | meaning
// IDLE  | waiting for start; loads the shift register when it arrives
// SHIFT | add-3 adjust then shift, five iterations
// DONE  | BCD result valid on Tens/Ones for this cycle, Busy drops
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] Bin,
    input  logic       start,
    output logic       Busy,
    output logic [3:0] Tens,
    output logic [3:0] Ones,
    output logic       done
);

    conv_state_t state;
    logic [12:0] shift_reg;
    logic [2:0]  iter;

    function automatic logic [12:0] dabble_adjust(input logic [12:0] v);
        logic [12:0] r;
        r = v;
        if (r[8:5] >= 4'd5)
            r[8:5] = r[8:5] + 4'd3;
        if (r[12:9] >= 4'd5)
            r[12:9] = r[12:9] + 4'd3;
        return r;
    endfunction

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= CONV_IDLE;
            shift_reg <= '0;
            iter      <= '0;
            Busy      <= 1'b0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        shift_reg <= {8'b0, Bin};
                        iter      <= '0;
                        Busy      <= 1'b1;
                        state     <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    shift_reg <= dabble_adjust(shift_reg) << 1;
                    iter      <= iter + 3'd1;
                    if (iter == 3'd4)
                        state <= CONV_DONE;
                end
                CONV_DONE: begin
                    Busy  <= 1'b0;
                    state <= CONV_IDLE;
                end
                default: state <= CONV_IDLE;
            endcase
        end
    end

    assign Tens = shift_reg[12:9];
    assign Ones = shift_reg[8:5];
    assign done = (state == CONV_DONE);

endmodule

// File: rtl/countdown_display.sv
// Two-digit multiplexed common-anode display of the controller countdown, with
// leading-zero blanking, yellow-stage blink and a dash pattern for the illegal stage.
module countdown_display
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 50000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] Cnt,
    input  logic [1:0] currStage,
    output logic [6:0] Seg,
    output logic [1:0] An,
    output logic       Busy
);

    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [4:0]         shadow;
    logic [3:0]         tens;
    logic [3:0]         ones;
    logic [3:0]         conv_tens;
    logic [3:0]         conv_ones;
    logic               conv_done;
    logic               start;
    logic [SCAN_W-1:0]  scan_cnt;
    logic               sel;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic [6:0]         seg_nxt;
    logic [1:0]         an_nxt;

    // Changes that arrive while busy are picked up by this compare once the converter idles.
    assign start = !Busy && (Cnt != shadow);

    bin2bcd_seq u_bin2bcd (
        .Clk   (Clk),
        .Rst   (Rst),
        .Bin   (Cnt),
        .start (start),
        .Busy  (Busy),
        .Tens  (conv_tens),
        .Ones  (conv_ones),
        .done  (conv_done)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shadow <= '0;
            tens   <= '0;
            ones   <= '0;
        end else begin
            if (start)
                shadow <= Cnt;
            if (conv_done) begin
                tens <= conv_tens;
                ones <= conv_ones;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= ~sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (currStage != STAGE_Y) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        seg_nxt = SEG_OFF;
        an_nxt  = sel ? 2'b01 : 2'b10;
        if (currStage == STAGE_X) begin
            seg_nxt = SEG_DASH;
        end else begin
            seg_nxt = digit_to_seg(sel ? tens : ones);
            if ((sel && tens == 4'd0) || (currStage == STAGE_Y && !blink_on))
                an_nxt = 2'b11;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Seg <= SEG_OFF;
            An  <= 2'b11;
        end else begin
            Seg <= seg_nxt;
            An  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// Randomized and directed bench for countdown_display against a cycle-count reference model.
module tb_countdown_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] Cnt;
    logic [1:0] currStage;
    logic [6:0] Seg;
    logic [1:0] An;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_edges, m_yel, m_busy_left, m_shadow, m_tens, m_ones;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_busy;
    logic [6:0] seg_codes [10];

    countdown_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Cnt       (Cnt),
        .currStage (currStage),
        .Seg       (Seg),
        .An        (An),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_edges = 0; m_yel = 0; m_busy_left = 0;
        m_shadow = 0; m_tens = 0; m_ones = 0;
        exp_seg = 7'b1111111; exp_an = 2'b11; exp_busy = 1'b0;
    endtask

    // Predicts what one rising edge does, from the inputs present at that edge.
    task automatic model_edge();
        int  sel;
        bit  on;
        sel = (m_edges / SCAN_DIV) % 2;
        on  = ((m_yel / BLINK_DIV) % 2) == 0;
        if (currStage == 2'b11) begin
            exp_seg = 7'b0111111;
            exp_an  = (sel == 1) ? 2'b01 : 2'b10;
        end else begin
            exp_seg = seg_codes[(sel == 1) ? m_tens : m_ones];
            if ((sel == 1 && m_tens == 0) || (currStage == 2'b10 && !on))
                exp_an = 2'b11;
            else
                exp_an = (sel == 1) ? 2'b01 : 2'b10;
        end
        m_edges++;
        m_yel = (currStage == 2'b10) ? m_yel + 1 : 0;
        if (m_busy_left == 0) begin
            if (int'(Cnt) != m_shadow) begin
                m_shadow    = int'(Cnt);
                m_busy_left = 6;
            end
        end else begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_tens = m_shadow / 10;
                m_ones = m_shadow % 10;
            end
        end
        exp_busy = (m_busy_left > 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        chk("seg", Seg, exp_seg);
        chk("an", {5'b0, An}, {5'b0, exp_an});
        chk("busy", {6'b0, Busy}, {6'b0, exp_busy});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Raise Rst between edges and check outputs before any clock arrives.
    task automatic do_reset();
        Rst = 1'b1;
        #1;
        model_reset();
        chk("rst_seg", Seg, 7'b1111111);
        chk("rst_an", {5'b0, An}, 7'b0000011);
        chk("rst_busy", {6'b0, Busy}, 7'b0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        seg_codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        Rst = 1'b1; Cnt = 5'd0; currStage = 2'b00;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        do_reset();
        steps(5);

        // 0 -> 30 on red: busy length and both scan slots
        Cnt = 5'd30;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            busy_cnt += int'(Busy);
        end
        chk("busy_len", 7'(busy_cnt), 7'd6);
        for (int i = 0; i < 8; i++) begin
            step();
            if (An == 2'b01) chk("tens30", Seg, 7'b0110000);
            else chk("ones30", Seg, 7'b1000000);
        end

        // 6 on green: tens slot blanked
        Cnt = 5'd6; currStage = 2'b01;
        steps(10);
        for (int i = 0; i < 8; i++) begin
            step();
            if (An != 2'b11) chk("ones6", {Seg[6:0]}, 7'b0000010);
            else chk("blank6", {5'b0, An}, 7'b0000011);
        end

        // 24 then 23 while busy: converges to 23
        Cnt = 5'd24; currStage = 2'b00;
        steps(2);
        Cnt = 5'd23;
        steps(14);
        for (int i = 0; i < 8; i++) begin
            step();
            if (An == 2'b01) chk("tens23", Seg, 7'b0100100);
            else chk("ones23", Seg, 7'b0110000);
        end

        // yellow blink, then back to red
        Cnt = 5'd6; currStage = 2'b10;
        steps(40);
        currStage = 2'b00;
        steps(4);

        // illegal stage: dashes, no blanking
        currStage = 2'b11;
        steps(2);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("dash", Seg, 7'b0111111);
        end

        // reset in the middle of a conversion
        currStage = 2'b00;
        Cnt = 5'd17;
        steps(3);
        Cnt = 5'd0;
        do_reset();
        steps(12);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) Cnt = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) currStage = 2'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
